muldiv_seq: RTL and testbench

Iterative RV32M multiply/divide sequencer in the Execute stage. It accepts one M-extension operation from the ALU decode path and runs a 32-iteration shift-add multiply or restoring divide over one shared 64-bit accumulator. It returns the 32-bit result through a valid/ready handshake. The pipeline controller stalls Execute while the block is busy.

---
 rtl/muldiv_seq_pkg.sv | 28 ++
 rtl/muldiv_seq.sv | 153 +++++++++++++++
 tb/tb_muldiv_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - RV32M funct3/opcode encodings and operand sign helpers
package muldiv_seq_pkg;

  // R-type arithmetic opcode; funct7=0000001 marks an M-extension op
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] FNC7_MULDIV   = 7'b0000001;

  localparam logic [2:0] FNC_MUL    = 3'd0;
  localparam logic [2:0] FNC_MULH   = 3'd1;
  localparam logic [2:0] FNC_MULHSU = 3'd2;
  localparam logic [2:0] FNC_MULHU  = 3'd3;
  localparam logic [2:0] FNC_DIV    = 3'd4;
  localparam logic [2:0] FNC_DIVU   = 3'd5;
  localparam logic [2:0] FNC_REM    = 3'd6;
  localparam logic [2:0] FNC_REMU   = 3'd7;

  // rs1 is a signed operand for every op except the fully unsigned ones
  function automatic logic signed_a(input logic [2:0] funct);
    return (funct != FNC_MULHU) && (funct != FNC_DIVU) && (funct != FNC_REMU);
  endfunction

  // rs2 is signed only for MUL, MULH, DIV and REM
  function automatic logic signed_b(input logic [2:0] funct);
    return (funct == FNC_MUL) || (funct == FNC_MULH) ||
           (funct == FNC_DIV) || (funct == FNC_REM);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M shift-add multiply / restoring divide sequencer
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            kill,
  output logic            busy,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]        state;
  logic [2:0]        funct;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              sign_a;
  logic              sign_b;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  cnt;

  logic              is_div;
  logic              in_sign_a, in_sign_b;
  logic [XLEN-1:0]   in_mag_a, in_mag_b;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN:0]   div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] calc_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   fix_result;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   a_orig;
  logic [XLEN-1:0]   special_result;

  assign is_div     = funct[2];
  assign req_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign resp_valid = (state == S_DONE);

  // Operand magnitudes and signs captured at accept
  always_comb begin
    in_sign_a = signed_a(req_funct) & req_a[XLEN-1];
    in_sign_b = signed_b(req_funct) & req_b[XLEN-1];
    in_mag_a  = in_sign_a ? -req_a : req_a;
    in_mag_b  = in_sign_b ? -req_b : req_b;
  end

  // One CALC iteration: multiply adds into the upper half then shifts right,
  // divide shifts {rem,quo} left and commits the trial subtraction if it fits
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : {(XLEN+1){1'b0}});
    div_shift = {acc, 1'b0};
    div_diff  = div_shift[2*XLEN:XLEN] - {1'b0, mag_b};
    if (is_div) begin
      if (div_diff[XLEN]) calc_next = div_shift[2*XLEN-1:0];
      else                calc_next = {div_diff[XLEN-1:0], div_shift[XLEN-1:1], 1'b1};
    end else begin
      calc_next = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Sign correction and result selection for the FIX cycle
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    quo_fix  = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (!is_div) fix_result = (funct[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else         fix_result = funct[1] ? rem_fix : quo_fix;
  end

  // Divide-by-zero and signed-overflow short cuts resolved in PREP
  always_comb begin
    div_zero = is_div && (mag_b == '0);
    div_ovf  = is_div && !funct[0] && sign_a && sign_b &&
               (mag_a == MIN_NEG) && (mag_b == XLEN'(1));
    a_orig   = sign_a ? -mag_a : mag_a;
    if (div_zero) special_result = funct[1] ? a_orig : {XLEN{1'b1}};
    else          special_result = funct[1] ? {XLEN{1'b0}} : MIN_NEG;
  end

  // Control FSM and shared accumulator datapath; kill aborts any busy state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      funct       <= '0;
      mag_a       <= '0;
      mag_b       <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      resp_result <= '0;
    end else if (kill && (state != S_IDLE)) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && !kill) begin
            funct  <= req_funct;
            mag_a  <= in_mag_a;
            mag_b  <= in_mag_b;
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            state  <= S_PREP;
          end
        end
        S_PREP: begin
          if (div_zero || div_ovf) begin
            resp_result <= special_result;
            state       <= S_DONE;
          end else begin
            acc   <= {{XLEN{1'b0}}, mag_a};
            cnt   <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          acc <= calc_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) state <= S_FIX;
        end
        S_FIX: begin
          resp_result <= fix_result;
          state       <= S_DONE;
        end
        S_DONE: begin
          if (resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard testbench for muldiv_seq
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct = 3'd0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        kill = 1'b0;
  logic        busy;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_result;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b), .kill(kill), .busy(busy),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every consumed response
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got 0x%08h with empty scoreboard", resp_result);
      end else begin
        check(name_q.pop_front(), resp_result, exp_q.pop_front());
      end
    end
  end

  // Present one op, wait for it to be accepted, optionally score it
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name, input bit push);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_ready_wait"}, 32'(guard < 100), 32'd1);
    req_valid = 1'b1;
    req_funct = f;
    req_a     = a;
    req_b     = b;
    if (push) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Count edges after accept until resp_valid; busy must stay high meanwhile
  task automatic wait_resp(input string name, input int exp_lat);
    int lat;
    bit busy_low;
    lat = 0;
    busy_low = 1'b0;
    while (!resp_valid && lat < 60) begin
      if (!busy) busy_low = 1'b1;
      @(posedge clk);
      #1 lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_busy_low"}, 32'(busy_low), 32'd0);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name, input int exp_lat);
    issue(f, a, b, exp, name, 1'b1);
    wait_resp(name, exp_lat);
  endtask

  initial begin
    int quiet;

    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_result", resp_result, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(FNC_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7_m3",    34);
    run_op(FNC_MULH,   32'h80000000,   32'h80000000, 32'h40000000, "mulh_min",    34);
    run_op(FNC_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max",   34);
    run_op(FNC_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1",   34);
    run_op(FNC_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, "div_m7_2",    34);
    run_op(FNC_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, "rem_m7_2",    34);
    run_op(FNC_DIVU,   32'd100,        32'd7,        32'd14,       "divu_100_7",  34);
    run_op(FNC_REMU,   32'd100,        32'd7,        32'd2,        "remu_100_7",  34);
    run_op(FNC_DIVU,   32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, "divu_max_1",  34);

    run_op(FNC_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, "divu_by0",    1);
    run_op(FNC_REM,    32'd5,          32'd0,        32'd5,        "rem_by0",     1);
    run_op(FNC_REM,    32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9, "rem_neg_by0", 1);
    run_op(FNC_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, "div_ovf",     1);
    run_op(FNC_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        "rem_ovf",     1);

    // kill while idle blocks acceptance
    @(negedge clk);
    req_valid = 1'b1;
    req_funct = FNC_MUL;
    kill      = 1'b1;
    @(posedge clk);
    #1 check("kill_idle_busy", 32'(busy), 32'd0);
    req_valid = 1'b0;
    kill      = 1'b0;

    // kill during CALC iteration 10: no response, idle next edge
    issue(FNC_MUL, 32'd9, 32'd9, 32'd0, "mul_killed", 1'b0);
    repeat (11) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1;
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_resp_valid", 32'(resp_valid), 32'd0);
    check("kill_req_ready", 32'(req_ready), 32'd1);
    kill  = 1'b0;
    quiet = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (resp_valid) quiet++;
    end
    check("kill_no_resp", 32'(quiet), 32'd0);
    run_op(FNC_MUL, 32'd3, 32'd4, 32'd12, "mul_after_kill", 34);

    // backpressure: result held 5 cycles, req_valid in DONE not taken
    @(posedge clk);
    #1 resp_ready = 1'b0;
    run_op(FNC_MUL, 32'h12345678, 32'h10, 32'h23456780, "mul_bp", 34);
    req_valid = 1'b1;
    req_funct = FNC_DIVU;
    req_a     = 32'd100;
    req_b     = 32'd7;
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_result_held", resp_result, 32'h23456780);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    check("bp_not_accepted", 32'(busy), 32'd0);
    exp_q.push_back(32'd14);
    name_q.push_back("divu_after_bp");
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("bp_accept_busy", 32'(busy), 32'd1);
    wait_resp("divu_after_bp", 34);

    // asynchronous reset mid-CALC takes effect without a clock edge
    issue(FNC_MUL, 32'd5, 32'd5, 32'd0, "mul_reset", 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_resp_valid", 32'(resp_valid), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_result", resp_result, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(FNC_MULHU, 32'h00010000, 32'h00010000, 32'd1, "mulhu_after_rst", 34);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
